// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with a per-frame
// input snapshot, inter-digit blanking, hours leading-zero blanking and colon blink.
module seg7_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sign0,
  input  logic [3:0] sign1,
  input  logic [3:0] sign2,
  input  logic [3:0] sign3,
  input  logic [3:0] seconds,
  output logic [6:0] segments,
  output logic [3:0] displays,
  output logic       dp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_V  = DW'(BLANK_CYC);

  typedef enum logic {SLOT_BLANK = 1'b0, SLOT_DRIVE = 1'b1} slot_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sh0_q, sh1_q, sh2_q, sh3_q;
  logic [3:0]    sh0_d, sh1_d, sh2_d, sh3_d;
  logic          sec_q, sec_d;
  logic [6:0]    segments_q, segments_d;
  logic [3:0]    displays_q, displays_d;
  logic          dp_q, dp_d;
  logic          blank_s;
  logic          load_s;
  logic [3:0]    cur_s;
  slot_e         slot_s;

  if (BLANK_CYC > 0) begin : g_blank
    assign blank_s = (div_q < BLANK_V);
  end else begin : g_noblank
    assign blank_s = 1'b0;
  end

  assign slot_s = blank_s ? SLOT_BLANK : SLOT_DRIVE;
  // Snapshot is taken only at the very start of a frame so a frame never mixes two times.
  assign load_s = (div_q == '0) && (idx_q == 2'd0);

  // State register: scan counters, shadow snapshot and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q      <= '0;
      idx_q      <= 2'd0;
      sh0_q      <= 4'd0;
      sh1_q      <= 4'd0;
      sh2_q      <= 4'd0;
      sh3_q      <= 4'd0;
      sec_q      <= 1'b0;
      segments_q <= 7'h7F;
      displays_q <= 4'b1111;
      dp_q       <= 1'b1;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      sh3_q      <= sh3_d;
      sec_q      <= sec_d;
      segments_q <= segments_d;
      displays_q <= displays_d;
      dp_q       <= dp_d;
    end
  end

  // Next-state: slot divider, digit index and frame snapshot.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    sh0_d = sh0_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    sh3_d = sh3_q;
    sec_d = sec_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
    if (load_s) begin
      sh0_d = sign0;
      sh1_d = sign1;
      sh2_d = sign2;
      sh3_d = sign3;
      sec_d = seconds[0];
    end else begin
      sec_d = sec_q;
    end
  end

  // Output next-state: dark during BLANK, one anode plus decoded digit during DRIVE.
  always_comb begin
    segments_d = 7'h7F;
    displays_d = 4'b1111;
    dp_d       = 1'b1;
    case (idx_q)
      2'd0:    cur_s = sh0_q;
      2'd1:    cur_s = sh1_q;
      2'd2:    cur_s = sh2_q;
      2'd3:    cur_s = sh3_q;
      default: cur_s = 4'd0;
    endcase
    case (slot_s)
      SLOT_DRIVE: begin
        if ((LZ_BLANK != 0) && (idx_q == 2'd3) && (sh3_q == 4'd0)) begin
          segments_d = 7'h7F;
          displays_d = 4'b1111;
        end else begin
          segments_d = seg_decode(cur_s);
          displays_d = ~(4'b0001 << idx_q);
        end
        if ((idx_q == 2'd2) && sec_q) begin
          dp_d = 1'b0;
        end else begin
          dp_d = 1'b1;
        end
      end
      default: begin
        segments_d = 7'h7F;
        displays_d = 4'b1111;
        dp_d       = 1'b1;
      end
    endcase
  end

  assign segments = segments_q;
  assign displays = displays_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (SCAN_DIV=8, BLANK_CYC=2, LZ_BLANK=1):
// a cycle-position model pushes expected outputs per edge, popped and compared after the edge.
module tb_seg7_scan_mux;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] sign0, sign1, sign2, sign3, seconds;
  logic [6:0] segments;
  logic [3:0] displays;
  logic       dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         pos      = 0;
  logic [3:0] snap [4];
  logic       snap_sec;

  seg7_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sign0    (sign0),
    .sign1    (sign1),
    .sign2    (sign2),
    .sign3    (sign3),
    .seconds  (seconds),
    .segments (segments),
    .displays (displays),
    .dp       (dp)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s pos=%0d got=%h exp=%h", tag, pos, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // One clock: predict the output produced by the coming edge, then compare after it.
  task automatic step(input string tag);
    exp_t e;
    exp_t got_e;
    int   slot;
    int   d;
    e.an  = 4'b1111;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (!rst_ni) begin
      pos = 0;
      for (int k = 0; k < 4; k++) snap[k] = 4'd0;
      snap_sec = 1'b0;
    end else begin
      slot = (pos / 8) % 4;
      d    = pos % 8;
      if (d >= 2) begin
        if (!(slot == 3 && snap[3] == 4'd0)) begin
          e.an  = ~(4'b0001 << slot);
          e.seg = exp_seg(snap[slot]);
        end
        e.dp = !(slot == 2 && snap_sec);
      end
      if (pos % 32 == 0) begin
        snap[0]  = sign0;
        snap[1]  = sign1;
        snap[2]  = sign2;
        snap[3]  = sign3;
        snap_sec = seconds[0];
      end
      pos++;
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    got_e = exp_q.pop_front();
    check_eq({tag, "_an"},  {8'd0, displays}, {8'd0, got_e.an});
    check_eq({tag, "_seg"}, {5'd0, segments}, {5'd0, got_e.seg});
    check_eq({tag, "_dp"},  {11'd0, dp},      {11'd0, got_e.dp});
    check_eq({tag, "_onehot"}, {11'd0, ($countones(~displays) <= 1)}, 12'd1);
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  task automatic run_until(input string tag, input int target);
    for (int i = 0; i < 64 && (pos % 32) != target; i++) step(tag);
    check_eq({tag, "_reach"}, 12'(pos % 32), 12'(target));
  endtask

  initial begin
    rst_ni  = 1'b0;
    sign0   = 4'd8;
    sign1   = 4'd8;
    sign2   = 4'd8;
    sign3   = 4'd8;
    seconds = 4'd1;
    @(negedge clk_i);
    run("reset", 3);
    sign0   = 4'd1;
    sign1   = 4'd2;
    sign2   = 4'd3;
    sign3   = 4'd1;
    seconds = 4'd0;
    rst_ni  = 1'b1;
    run("scan", 40);

    run_until("lz_sync", 0);
    sign3   = 4'd0;
    sign2   = 4'd9;
    seconds = 4'd1;
    run("lz", 64);
    seconds = 4'd2;
    run("dp_off", 32);

    sign0 = 4'd5;
    run_until("snap_sync", 0);
    run_until("snap_pre", 16);
    sign0 = 4'd7;
    run("snap", 40);

    sign1 = 4'hC;
    run("invalid", 40);

    run_until("midrst_sync", 21);
    rst_ni = 1'b0;
    run("midrst", 1);
    rst_ni = 1'b1;
    run("after_rst", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
